keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the scanned 7-segment output path: drives a 4x4 matrix
//  keypad one column at a time and reads its rows back. Synchronizes and debounces
//  the rows, then reports one key-press event per physical press.
//  Sits at the board-input boundary; key_code/key_valid feed the display and control logic.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per column slot (>=2); 1 ms at 50 MHz
//  DEBOUNCE_CNT  20     consecutive matching samples needed to accept a press or release (>=1)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous reset, active-low
//  row_in     in   4  keypad rows, active-low, asynchronous to clk
//  col_drive  out  4  column select, one-hot active-low (bit n low = column n driven)
//  key_code   out  4  last accepted key = row*4 + col; held until next accepted press
//  key_valid  out  1  one-cycle pulse when a press is accepted
//  key_held   out  1  high from accepted press until accepted release
// BEHAVIOUR
//  Reset (rst==0 at posedge): col_drive=4'b1110, key_code=0, key_valid=0, key_held=0,
//   state=SCAN, slot divider=0, debounce count=0, 2-flop row synchronizer=4'b1111.
//  row_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
//  Slot divider counts 0..SCAN_DIV-1 and wraps. Sample point = cycle with divider==SCAN_DIV-1.
//  Column index rotates 0->1->2->3->0 at each sample point only while state==SCAN;
//   it is frozen in DEBOUNCE, PRESSED and RELEASE.
//  Sample classification: exactly one row bit low = single key (row index r);
//   all high = none; two or more low = invalid (treated as none in SCAN/DEBOUNCE).
//  States (evaluated only at sample points):
//   SCAN: single key -> candidate={r,col}, count=1; if DEBOUNCE_CNT==1 accept (see below),
//         else go DEBOUNCE and freeze column. Otherwise rotate column.
//   DEBOUNCE: same single row as candidate -> count++; count reaching DEBOUNCE_CNT -> accept.
//         Any other pattern -> SCAN, count=0, column advances to next.
//   Accept: key_code<=r*4+col, key_valid pulses high for exactly the cycle after the
//         sample-point edge, key_held<=1, go PRESSED.
//   PRESSED: all rows high -> RELEASE, count=1 (DEBOUNCE_CNT==1: release accepted at once).
//         Any row low (including another row or multiple rows) -> stay; no new event.
//   RELEASE: all high -> count++; count reaching DEBOUNCE_CNT -> key_held<=0, SCAN,
//         column advances to next. Any row low -> PRESSED, no key_valid.
//  Latency: stable press on the driven column -> key_valid at most
//   2 + SCAN_DIV*DEBOUNCE_CNT + 1 cycles after row_in settles, given the column is being driven.
//  Reset mid-operation discards candidate/held state; a key still down after reset is
//   re-detected and reported as a new press.
//  key_valid is never high for two consecutive cycles; key_code changes only on accept.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3)
//  Idle, rows 4'b1111 -> col_drive 1110,1101,1011,0111,1110 changing every 4 cycles; key_valid stays 0.
//  Hold row2 while col1 driven -> col_drive frozen at 4'b1101, one key_valid pulse, key_code=4'd9, key_held=1.
//  Row2 low for only 2 samples then high -> no key_valid; rotation resumes at col2 (4'b1011).
//  During RELEASE, row low again after 1 high sample -> back to PRESSED, no second key_valid pulse.
//  Rows 4'b1001 on col0 -> no key_valid; column keeps rotating.
//  rst=0 for 1 cycle while PRESSED with key still down -> all outputs reset; key_valid re-fires after debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column per slot, synchronizes and
// debounces the rows, and emits one key_valid pulse per accepted physical press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_n;
  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] div;
  logic [1:0]       col, col_n;
  logic [1:0]       cand, cand_n;
  logic [CNT_W-1:0] count, count_n;
  logic [3:0]       code_n;
  logic             valid_n, held_n;
  logic             sample;
  logic             single;
  logic [1:0]       single_row;
  logic             all_high;

  // {single-key flag, row index}; two or more low rows report no single key
  function automatic logic [2:0] classify(input logic [3:0] rows);
    case (rows)
      4'b1110: classify = 3'b100;
      4'b1101: classify = 3'b101;
      4'b1011: classify = 3'b110;
      4'b0111: classify = 3'b111;
      default: classify = 3'b000;
    endcase
  endfunction

  assign sample                = (div == DIV_LAST);
  assign {single, single_row}  = classify(row_p1);
  assign all_high              = &row_p1;
  assign col_drive             = ~(4'b0001 << col);

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_p0    <= 4'b1111;
      row_p1    <= 4'b1111;
      div       <= '0;
      state     <= SCAN;
      col       <= 2'd0;
      cand      <= 2'd0;
      count     <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_p0    <= row_in;
      row_p1    <= row_p0;
      div       <= sample ? '0 : div + 1'b1;
      state     <= state_n;
      col       <= col_n;
      cand      <= cand_n;
      count     <= count_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    cand_n  = cand;
    count_n = count;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (single) begin
            cand_n  = single_row;
            count_n = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              code_n  = {single_row, col};
              valid_n = 1'b1;
              held_n  = 1'b1;
              count_n = '0;
              state_n = PRESSED;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (single && (single_row == cand)) begin
            if (count == CNT_LAST) begin
              code_n  = {single_row, col};
              valid_n = 1'b1;
              held_n  = 1'b1;
              count_n = '0;
              state_n = PRESSED;
            end else begin
              count_n = count + 1'b1;
            end
          end else begin
            count_n = '0;
            col_n   = col + 2'd1;
            state_n = SCAN;
          end
        end
        PRESSED: begin
          if (all_high) begin
            if (DEBOUNCE_CNT == 1) begin
              held_n  = 1'b0;
              count_n = '0;
              col_n   = col + 2'd1;
              state_n = SCAN;
            end else begin
              count_n = CNT_W'(1);
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (all_high) begin
            if (count == CNT_LAST) begin
              held_n  = 1'b0;
              count_n = '0;
              col_n   = col + 2'd1;
              state_n = SCAN;
            end else begin
              count_n = count + 1'b1;
            end
          end else begin
            // bounce during release: the key is still considered down
            count_n = '0;
            state_n = PRESSED;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural keypad matrix that pulls a row low when its key's column is driven.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  logic        ovr_en;
  logic [3:0]  ovr;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int double_cnt = 0;
  logic prev_valid = 1'b0;
  int n;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_drive[c]) row_in[r] = 1'b0;
    if (ovr_en) row_in = ovr;
  end

  always @(posedge clk) begin
    if (key_valid) vcount <= vcount + 1;
    if (key_valid && prev_valid) double_cnt <= double_cnt + 1;
    prev_valid <= key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (key_valid !== 1'b1 && waited < budget) begin
      step(1);
      waited++;
    end
  endtask

  initial begin
    rst = 1'b0; keys = '0; ovr_en = 1'b0; ovr = 4'b1111;
    step(3);
    check("rst_col",   col_drive, 4'b1110);
    check("rst_code",  key_code,  4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held",  key_held,  1'b0);

    @(negedge clk) rst = 1'b1;
    step(1);  check("idle_c0",  col_drive, 4'b1110);
    step(4);  check("idle_c1",  col_drive, 4'b1101);
    step(4);  check("idle_c2",  col_drive, 4'b1011);
    step(4);  check("idle_c3",  col_drive, 4'b0111);
    step(4);  check("idle_wrap", col_drive, 4'b1110);
    check("idle_novalid", vcount, 0);

    // key row2/col1 pressed while col0 is driven
    keys[9] = 1'b1;
    wait_valid(64, n);
    check("press9_seen",    key_valid, 1'b1);
    check("press9_latency", n, 15);
    check("press9_code",    key_code,  4'd9);
    check("press9_held",    key_held,  1'b1);
    check("press9_frozen",  col_drive, 4'b1101);
    step(1);
    check("press9_pulse1",  key_valid, 1'b0);
    keys = '0;

    // release bounce: one high sample, then row low again
    step(3);
    keys[9] = 1'b1;
    step(4);
    check("bounce_held", key_held, 1'b1);
    keys = '0;
    step(8);
    check("rel_held_mid", key_held, 1'b1);
    check("bounce_novalid", vcount, 1);
    step(4);
    check("rel_held_off", key_held,  1'b0);
    check("rel_col_next", col_drive, 4'b1011);

    // short press: two single-row samples, then release
    ovr = 4'b1011; ovr_en = 1'b1;
    step(8);
    check("short_frozen", col_drive, 4'b1011);
    ovr_en = 1'b0;
    step(4);
    check("short_resume", col_drive, 4'b0111);
    check("short_novalid", vcount, 1);

    // two rows low is not a key
    ovr = 4'b1001; ovr_en = 1'b1;
    step(8);
    check("multi_rotate", col_drive, 4'b1101);
    check("multi_noheld", key_held,  1'b0);
    check("multi_code",   key_code,  4'd9);
    ovr_en = 1'b0;
    check("multi_novalid", vcount, 1);

    // key row3/col0, then reset while it is held down
    keys[12] = 1'b1;
    wait_valid(64, n);
    check("press12_seen", key_valid, 1'b1);
    check("press12_code", key_code,  4'd12);
    check("press12_held", key_held,  1'b1);
    check("press12_col",  col_drive, 4'b1110);
    step(2);
    rst = 1'b0;
    step(1);
    check("mid_rst_col",   col_drive, 4'b1110);
    check("mid_rst_code",  key_code,  4'd0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held",  key_held,  1'b0);
    rst = 1'b1;
    wait_valid(64, n);
    check("redetect_seen",    key_valid, 1'b1);
    check("redetect_latency", n, 12);
    check("redetect_code",    key_code,  4'd12);
    check("redetect_held",    key_held,  1'b1);
    step(1);
    check("redetect_pulse1", key_valid, 1'b0);
    check("total_valid",     vcount, 3);
    check("no_double_pulse", double_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
